spi_xfer_ctrl: RTL
==================

Name: spi_xfer_ctrl

Overview:
Transfer sequencer and serial-clock generator for the SPI master shift register.
- On a `go` pulse it latches the divider and character length, asserts slave select and produces `sclk`.
- Produces one-cycle `pos_edge`/`neg_edge` strobes and `tip`/`last` for the shift register, then returns to idle with a `done` pulse.
- Sits between the Wishbone register file and the shift register.

Parameters:
- DIV_W, 16, width of the clock divider.
- SS_W, 8, number of slave-select lines.
- LEN_W, 7, width of the character-length field; value 0 means 2^LEN_W bits.

Ports:
- wb_clk  in  1  system clock; all logic on its rising edge.
- wb_reset  in  1  reset, asynchronous, active-high.
- go  in  1  start strobe; honoured only in IDLE.
- divider  in  DIV_W  half-period minus one, in wb_clk cycles.
- len  in  LEN_W  bits per character (0 = 128).
- ss_sel  in  SS_W  slave(s) to select.
- ass  in  1  auto slave select: 1 = ss driven only while tip; 0 = ss follows ss_sel directly.
- sclk  out  1  serial clock, idles low.
- pos_edge  out  1  one-cycle strobe; sclk rises at the end of this cycle.
- neg_edge  out  1  one-cycle strobe; sclk falls at the end of this cycle.
- tip  out  1  transfer in progress.
- last  out  1  final bit of the character in progress.
- ss_pad_o  out  SS_W  slave selects, active-low.
- done  out  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset values: state=IDLE, sclk=0, pos_edge=0, neg_edge=0, tip=0, last=0, done=0, divider counter=0, edge counter=0, ss_pad_o = all ones when ass=1. All registers are asynchronously cleared; reset mid-transfer aborts it with no done pulse.
- States: IDLE, START, SHIFT, HOLD.
- IDLE + go:
  - latch div_q=divider;
  - latch edge_cnt = 2*N, where N=len, or N=2^LEN_W when len==0 (edge_cnt is LEN_W+2 bits);
  - cnt=div_q; go to START.
- go while not IDLE is ignored. Changes to divider/len mid-transfer have no effect.
- cnt counts down every cycle in START/SHIFT/HOLD and reloads div_q on reaching 0; a "tick" is a cycle with cnt==0.
- START: on tick, go to SHIFT. This is the setup time for ss before the first edge.
- SHIFT: on each tick:
  - if sclk==0, assert pos_edge; otherwise assert neg_edge;
  - toggle sclk and decrement edge_cnt;
  - when edge_cnt goes 1→0, go to HOLD.
- HOLD: on tick, go to IDLE and assert done for exactly one cycle.
- tip = 1 in START/SHIFT/HOLD; tip rises the cycle after go.
- last = 1 in SHIFT while edge_cnt ≤ 2; otherwise 0.
- Edge strobes: never asserted outside SHIFT; never both in one cycle.
- sclk is always 0 in IDLE/START/HOLD, because the edge count is even.
- Timing: per-edge spacing is div_q+1 cycles; tip duration = (2N+2)*(div_q+1) cycles; divider=0 gives sclk = wb_clk/2.
- ss_pad_o:
  - if ass=1, ss_pad_o = ~(ss_sel & {SS_W{tip}});
  - if ass=0, ss_pad_o = ~ss_sel;
  - ss_pad_o is registered, so it changes one cycle after its source.

Optional Feature:
Macro SPI_XFER_CTRL_IRQ_EN.
- Defined: adds inputs `ie` (1) and `irq_clr` (1) and output `irq` (1).
  - A sticky flag sets on done.
  - irq_clr clears it; set wins over a simultaneous clear.
  - irq = flag & ie.
  - The flag resets to 0.
- Undefined: none of these ports or logic exist.

Decomposition:
- Package spi_ctrl_pkg holds:
  - the state encoding constants (IDLE=0, START=1, SHIFT=2, HOLD=3);
  - default DIV_W/SS_W/LEN_W;
  - a function returning 2*N from len.
- One sub-module is natural: spi_clk_div, holding the cnt countdown/reload and tick generation, with an enable input.

Test Plan:
1. Reset mid-SHIFT (divider=3, len=8) → next cycle: tip=0, sclk=0, no strobes, ss_pad_o=8'hFF, done never pulses; a following go starts cleanly.
2. divider=1, len=8, go → tip high for exactly 36 cycles; 8 pos_edge and 8 neg_edge strobes, alternating and starting with pos_edge, spaced 2 cycles apart; done pulses once as tip falls.
3. divider=0, len=0 → 256 strobes total; tip lasts 258 cycles; last is high only for the final 2 strobes.
4. go held high for the whole transfer, and divider changed from 1 to 5 mid-transfer → exactly one transfer, at 2-cycle edge spacing; after done, one more transfer starts because go is still high.
5. ass=1, ss_sel=8'h04 → ss_pad_o=8'hFB only while tip, else 8'hFF; with ass=0 → 8'hFB continuously.
6. With SPI_XFER_CTRL_IRQ_EN, ie=1 → irq rises after done; irq_clr on the same cycle as the next done leaves irq=1.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI transfer controller.
// Holds the FSM state encoding, default widths and the edge-count helper.
package spi_ctrl_pkg;

  localparam int unsigned DIV_W_DEF = 16;
  localparam int unsigned SS_W_DEF  = 8;
  localparam int unsigned LEN_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Number of sclk edges for a character: 2*len, where len==0 means 2^len_w bits.
  function automatic logic [31:0] edge_total(input logic [31:0] n, input int unsigned len_w);
    if (n == 32'd0) begin
      return 32'd1 << (len_w + 1);
    end
    return n << 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Divider countdown for the SPI serial clock.
// Ports:
//   wb_clk, wb_reset  clock and async active-high reset
//   load              capture divider into the reload register and counter
//   en                count down, reloading on zero
//   divider           half-period minus one
//   tick              registered: counter is zero this cycle
//   tick_nxt_c        combinational: counter will be zero next cycle
module spi_clk_div
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             wb_clk,
  input  logic             wb_reset,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] divider,
  output logic             tick,
  output logic             tick_nxt_c
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;

  // Next count: load wins, otherwise count down and reload on zero.
  always_comb begin
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = divider;
    end else if (en) begin
      cnt_nxt = (cnt == '0) ? div_q : cnt - DIV_W'(1);
    end
  end

  assign tick_nxt_c = (cnt_nxt == '0);

  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      div_q <= '0;
      cnt   <= '0;
      tick  <= 1'b1;
    end else begin
      if (load) begin
        div_q <= divider;
      end
      cnt  <= cnt_nxt;
      tick <= tick_nxt_c;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer and serial-clock generator.
// Ports:
//   wb_clk, wb_reset   clock and async active-high reset
//   go                 start strobe, honoured only when idle
//   divider, len       half-period minus one, bits per character (0 = 2^LEN_W)
//   ss_sel, ass        slave selection and auto-slave-select mode
//   sclk               serial clock, idles low
//   pos_edge/neg_edge  one-cycle strobes in the cycle before sclk rises/falls
//   tip, last          transfer in progress, final bit of the character
//   ss_pad_o           active-low slave selects
//   done               one-cycle pulse at transfer completion
// Optional macro SPI_XFER_CTRL_IRQ_EN adds ie/irq_clr inputs and a sticky irq output.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned SS_W  = SS_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             wb_clk,
  input  logic             wb_reset,
  input  logic             go,
  input  logic [DIV_W-1:0] divider,
  input  logic [LEN_W-1:0] len,
  input  logic [SS_W-1:0]  ss_sel,
  input  logic             ass,
`ifdef SPI_XFER_CTRL_IRQ_EN
  input  logic             ie,
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic             sclk,
  output logic             pos_edge,
  output logic             neg_edge,
  output logic             tip,
  output logic             last,
  output logic [SS_W-1:0]  ss_pad_o,
  output logic             done
);

  localparam int unsigned EDGE_W = LEN_W + 2;

  state_t            state;
  state_t            state_nxt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [EDGE_W-1:0] edge_cnt_nxt;
  logic              sclk_nxt;
  logic              done_nxt;
  logic              pos_nxt;
  logic              neg_nxt;
  logic              last_nxt;
  logic              tip_nxt;
  logic              tick;
  logic              tick_nxt_c;
  logic              load_c;
  logic              en_c;

  assign load_c = (state == IDLE) && go;
  assign en_c   = (state != IDLE);

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .wb_clk     (wb_clk),
    .wb_reset   (wb_reset),
    .load       (load_c),
    .en         (en_c),
    .divider    (divider),
    .tick       (tick),
    .tick_nxt_c (tick_nxt_c)
  );

  // State register.
  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus look-ahead for the registered strobes, so each strobe
  // lands in the same cycle as the tick that moves sclk.
  always_comb begin
    state_nxt    = state;
    edge_cnt_nxt = edge_cnt;
    sclk_nxt     = sclk;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt    = START;
          edge_cnt_nxt = EDGE_W'(edge_total(32'(len), LEN_W));
        end
      end
      START: begin
        if (tick) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_nxt     = ~sclk;
          edge_cnt_nxt = edge_cnt - EDGE_W'(1);
          if (edge_cnt == EDGE_W'(1)) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pos_nxt  = (state_nxt == SHIFT) && tick_nxt_c && !sclk_nxt;
    neg_nxt  = (state_nxt == SHIFT) && tick_nxt_c && sclk_nxt;
    last_nxt = (state_nxt == SHIFT) && (edge_cnt_nxt <= EDGE_W'(2));
    tip_nxt  = (state_nxt != IDLE);
  end

  // Datapath and output registers; ss follows its source one cycle later.
  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      edge_cnt <= '0;
      sclk     <= 1'b0;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
      last     <= 1'b0;
      tip      <= 1'b0;
      done     <= 1'b0;
      ss_pad_o <= '1;
    end else begin
      edge_cnt <= edge_cnt_nxt;
      sclk     <= sclk_nxt;
      pos_edge <= pos_nxt;
      neg_edge <= neg_nxt;
      last     <= last_nxt;
      tip      <= tip_nxt;
      done     <= done_nxt;
      ss_pad_o <= ass ? ~(ss_sel & {SS_W{tip}}) : ~ss_sel;
    end
  end

`ifdef SPI_XFER_CTRL_IRQ_EN
  logic irq_flag;
  logic irq_flag_nxt;

  // Sticky completion flag; a set beats a simultaneous clear.
  assign irq_flag_nxt = done | (irq_flag & ~irq_clr);

  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      irq_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_flag <= irq_flag_nxt;
      irq      <= irq_flag_nxt & ie;
    end
  end
`endif

endmodule
